// File: rtl/touch_spi_pkg.sv
// Shared types and constants for the touch-panel SPI responder.
package touch_spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_START,
    CMD,
    BUSY,
    DATA,
    TAIL
  } state_t;

  localparam logic [2:0] CH_X  = 3'b101;
  localparam logic [2:0] CH_Y  = 3'b001;
  localparam logic [2:0] CH_Z1 = 3'b011;

  localparam int CMD_W     = 8;
  localparam int MODE8_BIT = 3;

endpackage

// File: rtl/spi_in_sync.sv
// Synchronises the slow SPI master pins (and pen_down) into csi_clk and
// detects SCLK edges against the previous synchronised sample.
module spi_in_sync
  import touch_spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic tcs,
  input  logic sclk,
  input  logic mosi,
  input  logic pen,
  output logic cs_n,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic mosi_s,
  output logic pen_s
);

  logic [SYNC_STAGES-1:0] tcs_q, tcs_d;
  logic [SYNC_STAGES-1:0] sclk_q, sclk_d;
  logic [SYNC_STAGES-1:0] mosi_q, mosi_d;
  logic [SYNC_STAGES-1:0] pen_q, pen_d;
  logic                   sclk_prev_q, sclk_prev_d;

  always_comb begin
    tcs_d       = {tcs_q[SYNC_STAGES-2:0], tcs};
    sclk_d      = {sclk_q[SYNC_STAGES-2:0], sclk};
    mosi_d      = {mosi_q[SYNC_STAGES-2:0], mosi};
    pen_d       = {pen_q[SYNC_STAGES-2:0], pen};
    sclk_prev_d = sclk_q[SYNC_STAGES-1];
  end

  // Reset levels match the idle bus: deselected, clock high.
  always_ff @(posedge clk) begin
    if (rst) begin
      tcs_q       <= '1;
      sclk_q      <= '1;
      mosi_q      <= '0;
      pen_q       <= '0;
      sclk_prev_q <= 1'b1;
    end else begin
      tcs_q       <= tcs_d;
      sclk_q      <= sclk_d;
      mosi_q      <= mosi_d;
      pen_q       <= pen_d;
      sclk_prev_q <= sclk_prev_d;
    end
  end

  assign cs_n      = tcs_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_q[SYNC_STAGES-1];
  assign pen_s     = pen_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_q[SYNC_STAGES-1] & ~sclk_prev_q;
  assign sclk_fall = ~sclk_q[SYNC_STAGES-1] & sclk_prev_q;

endmodule

// File: rtl/touch_spi_responder.sv
// XPT2046-style touch controller emulation: decodes an 8-bit command from
// the oversampled SPI master and shifts back a latched sample on MISO.
//
// state      | meaning
// IDLE       | TCS high, MISO released
// WAIT_START | selected, skipping leading zeros until a start bit
// CMD        | shifting in remaining command bits
// BUSY       | next SCLK fall drives the busy bit
// DATA       | each SCLK fall drives one sample bit, MSB first
// TAIL       | MISO held low, a start bit begins an overlapped command
module touch_spi_responder
  import touch_spi_pkg::*;
#(
  parameter int DATA_W      = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic              csi_clk,
  input  logic              csi_reset,
  input  logic              TCS,
  input  logic              SCLK,
  input  logic              MOSI,
  output logic              MISO,
  output logic              MISO_OE,
  input  logic [DATA_W-1:0] x_data,
  input  logic [DATA_W-1:0] y_data,
  input  logic [DATA_W-1:0] z1_data,
  input  logic              pen_down,
  output logic              PENIRQ,
  output logic              cmd_strobe,
  output logic [CMD_W-1:0]  cmd_byte
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic cs_n, sclk_rise, sclk_fall, mosi_s, pen_s;

  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (csi_clk),
    .rst       (csi_reset),
    .tcs       (TCS),
    .sclk      (SCLK),
    .mosi      (MOSI),
    .pen       (pen_down),
    .cs_n      (cs_n),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .mosi_s    (mosi_s),
    .pen_s     (pen_s)
  );

  state_t            state_q, state_d;
  logic [CMD_W-2:0]  shift_q, shift_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] sample_q, sample_d;
  logic              mode8_q, mode8_d;
  logic              miso_q, miso_d;
  logic              miso_oe_q, miso_oe_d;
  logic              penirq_q, penirq_d;
  logic              cmd_strobe_q, cmd_strobe_d;
  logic [CMD_W-1:0]  cmd_byte_q, cmd_byte_d;
  logic [CMD_W-1:0]  cmd_next;

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    cnt_d        = cnt_q;
    sample_d     = sample_q;
    mode8_d      = mode8_q;
    miso_d       = miso_q;
    cmd_strobe_d = 1'b0;
    cmd_byte_d   = cmd_byte_q;
    cmd_next     = {shift_q, mosi_s};

    // Deselect wins over any SCLK edge seen in the same cycle.
    if (cs_n) begin
      state_d = IDLE;
      miso_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = WAIT_START;
          miso_d  = 1'b0;
        end
        WAIT_START: begin
          if (sclk_rise && mosi_s) begin
            shift_d = (CMD_W-1)'(1);
            cnt_d   = CNT_W'(CMD_W - 1);
            state_d = CMD;
          end
        end
        CMD: begin
          if (sclk_rise) begin
            shift_d = cmd_next[CMD_W-2:0];
            if (cnt_q == CNT_W'(1)) begin
              cmd_byte_d   = cmd_next;
              cmd_strobe_d = 1'b1;
              mode8_d      = cmd_next[MODE8_BIT];
              case (cmd_next[CMD_W-2 -: 3])
                CH_X:    sample_d = x_data;
                CH_Y:    sample_d = y_data;
                CH_Z1:   sample_d = z1_data;
                default: sample_d = '0;
              endcase
              state_d = BUSY;
            end else begin
              cnt_d = cnt_q - CNT_W'(1);
            end
          end
        end
        BUSY: begin
          if (sclk_fall) begin
            miso_d  = 1'b0;
            cnt_d   = mode8_q ? CNT_W'(8) : CNT_W'(DATA_W);
            state_d = DATA;
          end
        end
        DATA: begin
          if (sclk_fall) begin
            if (cnt_q == '0) begin
              miso_d  = 1'b0;
              state_d = TAIL;
            end else begin
              miso_d   = sample_q[DATA_W-1];
              sample_d = {sample_q[DATA_W-2:0], 1'b0};
              cnt_d    = cnt_q - CNT_W'(1);
            end
          end
        end
        TAIL: begin
          if (sclk_rise && mosi_s) begin
            shift_d = (CMD_W-1)'(1);
            cnt_d   = CNT_W'(CMD_W - 1);
            state_d = CMD;
          end else if (sclk_fall) begin
            miso_d = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    miso_oe_d = (state_d != IDLE);
    penirq_d  = (state_d == IDLE || state_d == WAIT_START) ? ~pen_s : 1'b1;
  end

  always_ff @(posedge csi_clk) begin
    if (csi_reset) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      cnt_q        <= '0;
      sample_q     <= '0;
      mode8_q      <= 1'b0;
      miso_q       <= 1'b0;
      miso_oe_q    <= 1'b0;
      penirq_q     <= 1'b1;
      cmd_strobe_q <= 1'b0;
      cmd_byte_q   <= '0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      cnt_q        <= cnt_d;
      sample_q     <= sample_d;
      mode8_q      <= mode8_d;
      miso_q       <= miso_d;
      miso_oe_q    <= miso_oe_d;
      penirq_q     <= penirq_d;
      cmd_strobe_q <= cmd_strobe_d;
      cmd_byte_q   <= cmd_byte_d;
    end
  end

  assign MISO       = miso_q;
  assign MISO_OE    = miso_oe_q;
  assign PENIRQ     = penirq_q;
  assign cmd_strobe = cmd_strobe_q;
  assign cmd_byte   = cmd_byte_q;

endmodule
